// File: rtl/blink_period_monitor_if.sv
// Bundles the monitored input, the clear control and the status outputs
// of the blink period monitor into one connection.
interface blink_period_monitor_if #(
    parameter int CNT_W = 16
);
    logic             blink_in;
    logic             clear;
    logic [CNT_W-1:0] half_period;
    logic             period_valid;
    logic             locked;
    logic [7:0]       mismatch_count;
    logic             timeout;

    // Side that drives the square wave and observes status.
    modport master (
        output blink_in,
        output clear,
        input  half_period,
        input  period_valid,
        input  locked,
        input  mismatch_count,
        input  timeout
    );

    // The monitor itself.
    modport slave (
        input  blink_in,
        input  clear,
        output half_period,
        output period_valid,
        output locked,
        output mismatch_count,
        output timeout
    );
endinterface

// File: rtl/blink_period_monitor.sv
// Measures the number of cycles between successive toggles of blink_in,
// compares each interval against EXPECTED_HALF +/- TOLERANCE, and reports
// lock, a saturating mismatch count and a sticky loss-of-activity flag.
module blink_period_monitor #(
    parameter int EXPECTED_HALF  = 128,
    parameter int TOLERANCE      = 0,
    parameter int LOCK_COUNT     = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    blink_period_monitor_if.slave  bus
);
    localparam int GR_W = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_blink_q;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [GR_W-1:0]    r_good_run;
    logic [GR_W-1:0]    w_good_run_nxt;
    logic [CNT_W-1:0]   r_half_period;
    logic [CNT_W-1:0]   w_half_period_nxt;
    logic               r_period_valid;
    logic               w_period_valid_nxt;
    logic               r_locked;
    logic [7:0]         r_mismatch_count;
    logic [7:0]         w_mismatch_count_nxt;
    logic               r_timeout;
    logic               w_timeout_nxt;

    logic               w_edge;
    logic [CNT_W:0]     w_meas;
    logic signed [CNT_W+1:0] w_diff;
    logic [CNT_W+1:0]   w_abs;
    logic               w_in_tol;
    logic               w_timeout_hit;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [GR_W-1:0]    w_good_inc;
    logic [7:0]         w_mismatch_inc;

    assign w_edge    = (bus.blink_in != r_blink_q);
    assign w_meas    = {1'b0, r_cnt} + (CNT_W+1)'(1);
    assign w_diff    = $signed({1'b0, w_meas}) - $signed((CNT_W+2)'(EXPECTED_HALF));
    assign w_abs     = w_diff[CNT_W+1] ? $unsigned(-w_diff) : $unsigned(w_diff);
    assign w_in_tol  = (w_abs <= (CNT_W+2)'(TOLERANCE));

    // An edge on the same cycle as the limit takes precedence over timeout.
    assign w_timeout_hit  = !w_edge && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_cnt_inc      = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_good_inc     = r_good_run + GR_W'(1);
    assign w_mismatch_inc = (r_mismatch_count == 8'hFF) ? r_mismatch_count
                                                        : r_mismatch_count + 8'd1;

    // Next-state and next-value decode for state, counters and status.
    always_comb begin
        w_state_nxt          = r_state;
        w_cnt_nxt            = r_cnt;
        w_good_run_nxt       = r_good_run;
        w_half_period_nxt    = r_half_period;
        w_period_valid_nxt   = 1'b0;
        w_mismatch_count_nxt = r_mismatch_count;
        w_timeout_nxt        = r_timeout;

        if (bus.clear) begin
            w_state_nxt          = ST_IDLE;
            w_cnt_nxt            = '0;
            w_good_run_nxt       = '0;
            w_half_period_nxt    = '0;
            w_mismatch_count_nxt = '0;
            w_timeout_nxt        = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cnt_nxt = '0;
                    if (w_edge) begin
                        w_state_nxt = ST_MEASURE;
                    end
                end
                ST_MEASURE, ST_LOCKED: begin
                    if (w_edge) begin
                        w_cnt_nxt          = '0;
                        w_half_period_nxt  = w_meas[CNT_W-1:0];
                        w_period_valid_nxt = 1'b1;
                        if (w_in_tol) begin
                            if (r_state == ST_MEASURE) begin
                                w_good_run_nxt = w_good_inc;
                                if (w_good_inc == GR_W'(LOCK_COUNT)) begin
                                    w_state_nxt = ST_LOCKED;
                                end
                            end
                        end else begin
                            w_good_run_nxt       = '0;
                            w_mismatch_count_nxt = w_mismatch_inc;
                            w_state_nxt          = ST_MEASURE;
                        end
                    end else if (w_timeout_hit) begin
                        w_cnt_nxt      = '0;
                        w_good_run_nxt = '0;
                        w_timeout_nxt  = 1'b1;
                        w_state_nxt    = ST_IDLE;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State and datapath registers; locked decodes the next state so it
    // moves together with the period_valid pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= ST_IDLE;
            r_blink_q        <= 1'b0;
            r_cnt            <= '0;
            r_good_run       <= '0;
            r_half_period    <= '0;
            r_period_valid   <= 1'b0;
            r_locked         <= 1'b0;
            r_mismatch_count <= '0;
            r_timeout        <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_blink_q        <= bus.blink_in;
            r_cnt            <= w_cnt_nxt;
            r_good_run       <= w_good_run_nxt;
            r_half_period    <= w_half_period_nxt;
            r_period_valid   <= w_period_valid_nxt;
            r_locked         <= (w_state_nxt == ST_LOCKED);
            r_mismatch_count <= w_mismatch_count_nxt;
            r_timeout        <= w_timeout_nxt;
        end
    end

    assign bus.half_period    = r_half_period;
    assign bus.period_valid   = r_period_valid;
    assign bus.locked         = r_locked;
    assign bus.mismatch_count = r_mismatch_count;
    assign bus.timeout        = r_timeout;
endmodule

// File: tb/tb_blink_period_monitor.sv
// Scoreboard bench: two monitors (TOLERANCE 0 and 2) watch the same
// blink stimulus; expected pulses are queued by the stimulus and popped
// by a monitor process on every period_valid.
module tb_blink_period_monitor;
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic blink   = 1'b0;
    logic clr     = 1'b0;

    always #5 clk = ~clk;

    blink_period_monitor_if #(.CNT_W(16)) ifa ();
    blink_period_monitor_if #(.CNT_W(16)) ifb ();

    assign ifa.blink_in = blink;
    assign ifa.clear    = clr;
    assign ifb.blink_in = blink;
    assign ifb.clear    = clr;

    blink_period_monitor #(
        .EXPECTED_HALF(128), .TOLERANCE(0), .LOCK_COUNT(4),
        .TIMEOUT_CYCLES(1024), .CNT_W(16)
    ) u_dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa.slave)
    );

    blink_period_monitor #(
        .EXPECTED_HALF(128), .TOLERANCE(2), .LOCK_COUNT(4),
        .TIMEOUT_CYCLES(1024), .CNT_W(16)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb.slave)
    );

    typedef struct packed {
        logic [15:0] hp;
        logic        lk;
        logic [7:0]  mm;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic exp_t mk(input int hp, input bit lk, input int mm);
        exp_t e;
        e.hp = 16'(hp);
        e.lk = lk;
        e.mm = 8'(mm);
        return e;
    endfunction

    function automatic logic [31:0] status(input logic [15:0] hp, input logic pv,
                                           input logic lk, input logic [7:0] mm,
                                           input logic to);
        return {5'b0, hp, pv, lk, mm, to};
    endfunction

    // Monitor: every period_valid must match the next queued expectation.
    always @(negedge clk) begin
        if (reset_n) begin
            if (ifa.period_valid) begin
                if (qa.size() == 0) begin
                    n_checks++;
                    $display("FAIL pulse_a: unexpected period_valid hp=%0d at %0t", ifa.half_period, $time);
                end else begin
                    ea = qa.pop_front();
                    check("pulse_a{hp,lk,mm}", {7'b0, ifa.half_period, ifa.locked, ifa.mismatch_count}, {7'b0, ea});
                end
            end
            if (ifb.period_valid) begin
                if (qb.size() == 0) begin
                    n_checks++;
                    $display("FAIL pulse_b: unexpected period_valid hp=%0d at %0t", ifb.half_period, $time);
                end else begin
                    eb = qb.pop_front();
                    check("pulse_b{hp,lk,mm}", {7'b0, ifb.half_period, ifb.locked, ifb.mismatch_count}, {7'b0, eb});
                end
            end
        end
    end

    task automatic tog(input int n);
        repeat (n) @(posedge clk);
        #1 blink = ~blink;
    endtask

    task automatic pulse(input int n, input exp_t xa, input exp_t xb);
        qa.push_back(xa);
        qb.push_back(xb);
        tog(n);
    endtask

    initial begin
        // Reset state
        #23;
        check("reset_a", status(ifa.half_period, ifa.period_valid, ifa.locked, ifa.mismatch_count, ifa.timeout), 32'd0);
        check("reset_b", status(ifb.half_period, ifb.period_valid, ifb.locked, ifb.mismatch_count, ifb.timeout), 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;

        // Nominal 128-cycle toggling: lock on 4th pulse
        tog(3);
        for (int k = 1; k <= 5; k++) pulse(128, mk(128, k >= 4, 0), mk(128, k >= 4, 0));
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;

        // 130-cycle toggling: A mismatches each time, B (tol 2) locks
        tog(5);
        for (int k = 1; k <= 5; k++) pulse(130, mk(130, 1'b0, k), mk(130, k >= 4, 0));

        // Hold constant: timeout exactly 1024 cycles after the last edge
        @(posedge clk);
        repeat (1023) @(posedge clk);
        #1;
        check("timeout_a_early", 32'(ifa.timeout), 32'd0);
        check("timeout_b_early", 32'(ifb.timeout), 32'd0);
        check("locked_b_before_timeout", 32'(ifb.locked), 32'd1);
        @(posedge clk); #1;
        check("timeout_a", 32'(ifa.timeout), 32'd1);
        check("timeout_b", 32'(ifb.timeout), 32'd1);
        check("locked_b_after_timeout", 32'(ifb.locked), 32'd0);
        check("locked_a_after_timeout", 32'(ifa.locked), 32'd0);
        // First edge after timeout produces no pulse, the next one does
        tog(10);
        pulse(128, mk(128, 1'b0, 5), mk(128, 1'b0, 0));
        repeat (3) @(posedge clk); #1;
        check("timeout_a_sticky", 32'(ifa.timeout), 32'd1);

        // Clear coincident with an edge
        @(posedge clk); #1 clr = 1'b1; blink = ~blink;
        @(posedge clk); #1 clr = 1'b0;
        check("clear_a", status(ifa.half_period, ifa.period_valid, ifa.locked, ifa.mismatch_count, ifa.timeout), 32'd0);
        check("clear_b", status(ifb.half_period, ifb.period_valid, ifb.locked, ifb.mismatch_count, ifb.timeout), 32'd0);
        tog(100);
        for (int k = 1; k <= 4; k++) pulse(128, mk(128, k == 4, 0), mk(128, k == 4, 0));

        // Asynchronous reset while locked, between clock edges
        @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0; blink = 1'b0;
        #1;
        check("async_reset_a", status(ifa.half_period, ifa.period_valid, ifa.locked, ifa.mismatch_count, ifa.timeout), 32'd0);
        check("async_reset_b", status(ifb.half_period, ifb.period_valid, ifb.locked, ifb.mismatch_count, ifb.timeout), 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;

        // 300 out-of-tolerance intervals: mismatch_count saturates at 255
        tog(4);
        for (int k = 1; k <= 300; k++)
            pulse(20, mk(20, 1'b0, (k > 255) ? 255 : k), mk(20, 1'b0, (k > 255) ? 255 : k));
        repeat (5) @(posedge clk); #1;
        check("sat_a", 32'(ifa.mismatch_count), 32'd255);
        check("queue_a_drained", 32'(qa.size()), 32'd0);
        check("queue_b_drained", 32'(qb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
